// File: rtl/monster_random_move_ctrl.sv
`timescale 1ns/1ps
// Random-walk controller for a monster sprite: collects blocked directions per frame,
// picks a direction from an LFSR (with hold), and moves with bound saturation.
module monster_random_move_ctrl #(
    parameter int          INITIAL_X   = 280,
    parameter int          INITIAL_Y   = 185,
    parameter int          SPEED       = 2,
    parameter int          X_MIN       = 0,
    parameter int          X_MAX       = 607,
    parameter int          Y_MIN       = 0,
    parameter int          Y_MAX       = 447,
    parameter int          HOLD_FRAMES = 8,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic [1:0]  collisionReq,
    input  logic        collisionValid,
    output logic [1:0]  random_move,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic        stuck,
    output logic        moveDone
);

    typedef enum logic [1:0] {ST_COLLECT, ST_DECIDE, ST_MOVE} state_t;
    typedef enum logic [1:0] {DIR_RIGHT = 2'b00, DIR_LEFT = 2'b01, DIR_DOWN = 2'b10, DIR_UP = 2'b11} dir_t;

    localparam int HW = (HOLD_FRAMES > 2) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic signed [11:0] STEP = 12'(SPEED);
    localparam logic signed [11:0] XLO  = 12'(X_MIN);
    localparam logic signed [11:0] XHI  = 12'(X_MAX);
    localparam logic signed [11:0] YLO  = 12'(Y_MIN);
    localparam logic signed [11:0] YHI  = 12'(Y_MAX);

    state_t          state_q, state_d;
    dir_t            dir_q, dir_d;
    logic [3:0]      mask_q, mask_d;
    logic [3:0]      blocked_q, blocked_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [7:0]      lfsr_q, lfsr_d;
    logic [10:0]     x_q, x_d, y_q, y_d;
    logic            stuck_q, stuck_d;
    logic            done_q, done_d;
    logic [3:0]      hit_vec;
    logic [1:0]      cand;
    logic            found;

    function automatic logic [10:0] sat_step(input logic [10:0] pos,
                                             input logic signed [11:0] delta,
                                             input logic signed [11:0] lo,
                                             input logic signed [11:0] hi);
        logic signed [11:0] v;
        v = $signed({1'b0, pos}) + delta;
        if (v < lo)      return lo[10:0];
        else if (v > hi) return hi[10:0];
        else             return v[10:0];
    endfunction

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= ST_COLLECT;
            dir_q     <= DIR_RIGHT;
            mask_q    <= '0;
            blocked_q <= '0;
            hold_q    <= '0;
            lfsr_q    <= LFSR_SEED;
            x_q       <= 11'(INITIAL_X);
            y_q       <= 11'(INITIAL_Y);
            stuck_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            mask_q    <= mask_d;
            blocked_q <= blocked_d;
            hold_q    <= hold_d;
            lfsr_q    <= lfsr_d;
            x_q       <= x_d;
            y_q       <= y_d;
            stuck_q   <= stuck_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        hit_vec   = collisionValid ? (4'b0001 << collisionReq) : '0;
        lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        state_d   = state_q;
        mask_d    = mask_q | hit_vec;
        blocked_d = blocked_q;
        dir_d     = dir_q;
        hold_d    = hold_q;
        stuck_d   = stuck_q;
        x_d       = x_q;
        y_d       = y_q;
        done_d    = 1'b0;
        cand      = '0;
        found     = 1'b0;

        case (state_q)
            ST_COLLECT: begin
                if (startOfFrame) begin
                    blocked_d = mask_q | hit_vec;
                    mask_d    = '0;
                    state_d   = ST_DECIDE;
                end
            end
            ST_DECIDE: begin
                state_d = ST_MOVE;
                if (!blocked_q[dir_q] && hold_q != '0) begin
                    hold_d  = hold_q - 1'b1;
                    stuck_d = 1'b0;
                end else if (&blocked_q) begin
                    stuck_d = 1'b1;
                end else begin
                    // rotate from the LFSR-chosen start; first free candidate wins
                    for (int unsigned k = 0; k < 4; k++) begin
                        cand = lfsr_q[1:0] + 2'(k);
                        if (!found && !blocked_q[cand]) begin
                            found = 1'b1;
                            dir_d = dir_t'(cand);
                        end
                    end
                    hold_d  = HW'(HOLD_FRAMES - 1);
                    stuck_d = 1'b0;
                end
            end
            ST_MOVE: begin
                state_d = ST_COLLECT;
                done_d  = 1'b1;
                if (!stuck_q) begin
                    case (dir_q)
                        DIR_RIGHT: x_d = sat_step(x_q, STEP, XLO, XHI);
                        DIR_LEFT:  x_d = sat_step(x_q, -STEP, XLO, XHI);
                        DIR_DOWN:  y_d = sat_step(y_q, STEP, YLO, YHI);
                        DIR_UP:    y_d = sat_step(y_q, -STEP, YLO, YHI);
                        default:   x_d = x_q;
                    endcase
                end
            end
            default: state_d = ST_COLLECT;
        endcase
    end

    assign random_move = dir_q;
    assign topLeftX    = x_q;
    assign topLeftY    = y_q;
    assign stuck       = stuck_q;
    assign moveDone    = done_q;

endmodule

// File: tb/tb_monster_random_move_ctrl.sv
`timescale 1ns/1ps
// Randomized frame-level bench for monster_random_move_ctrl against a behavioural model.
module tb_monster_random_move_ctrl;

    logic        clk = 1'b0;
    logic        resetN;
    logic        startOfFrame;
    logic [1:0]  collisionReq;
    logic        collisionValid;
    logic [1:0]  random_move;
    logic [10:0] topLeftX;
    logic [10:0] topLeftY;
    logic        stuck;
    logic        moveDone;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    monster_random_move_ctrl dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .collisionReq(collisionReq), .collisionValid(collisionValid),
        .random_move(random_move), .topLeftX(topLeftX), .topLeftY(topLeftY),
        .stuck(stuck), .moveDone(moveDone)
    );

    // Model state
    logic [7:0] m_lfsr;
    logic [3:0] m_mask, m_blocked;
    int m_x, m_y, m_dir, m_hold;
    bit m_stuck;

    always @(posedge clk or negedge resetN)
        if (!resetN) m_lfsr <= 8'hA5;
        else         m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};

    function automatic int clamp(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        #2 resetN = 1'b0;
        #1;
        checks++;
        if ({topLeftX, topLeftY, random_move, stuck, moveDone} !== {11'd280, 11'd185, 2'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_async: got x=%0d y=%0d dir=%0d stuck=%0b done=%0b, expected x=280 y=185 dir=0 stuck=0 done=0",
                     topLeftX, topLeftY, random_move, stuck, moveDone);
        end
        startOfFrame = 1'b0; collisionValid = 1'b0; collisionReq = 2'd0;
        m_x = 280; m_y = 185; m_dir = 0; m_hold = 0; m_stuck = 1'b0;
        m_mask = '0; m_blocked = '0;
        @(negedge clk);
        resetN = 1'b1;
        tick();
    endtask

    // One full frame: pre-SOF hits, SOF (optional coincident hit), DECIDE (optional hit), MOVE.
    task automatic run_frame(input logic [3:0] pre, input bit sh_en, input logic [1:0] sh,
                             input bit dh_en, input logic [1:0] dh, input bit xsof);
        int c, d;
        for (int i = 0; i < 4; i++) begin
            if (pre[i]) begin
                collisionValid = 1'b1; collisionReq = 2'(i);
                tick();
                m_mask[i] = 1'b1;
            end
        end
        collisionValid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
        startOfFrame = 1'b1; collisionValid = sh_en; collisionReq = sh;
        tick();
        m_blocked = m_mask;
        if (sh_en) m_blocked[sh] = 1'b1;
        m_mask = '0;
        c = int'(m_lfsr[1:0]);
        startOfFrame = xsof; collisionValid = dh_en; collisionReq = dh;
        tick();
        if (dh_en) m_mask[dh] = 1'b1;
        collisionValid = 1'b0;
        if (!m_blocked[m_dir] && m_hold > 0) begin
            m_hold--; m_stuck = 1'b0;
        end else if (m_blocked == 4'hF) begin
            m_stuck = 1'b1;
        end else begin
            for (int k = 0; k < 4; k++) begin
                d = (c + k) % 4;
                if (!m_blocked[d]) begin m_dir = d; break; end
            end
            m_hold = 7; m_stuck = 1'b0;
        end
        checks++;
        if (random_move !== 2'(m_dir)) begin
            errors++;
            $display("FAIL decide_dir: got %0d expected %0d (blocked=%b)", random_move, m_dir, m_blocked);
        end
        checks++;
        if (stuck !== m_stuck) begin
            errors++;
            $display("FAIL decide_stuck: got %0b expected %0b (blocked=%b)", stuck, m_stuck, m_blocked);
        end
        tick();
        startOfFrame = 1'b0;
        if (!m_stuck) begin
            case (m_dir)
                0: m_x = clamp(m_x + 2, 0, 607);
                1: m_x = clamp(m_x - 2, 0, 607);
                2: m_y = clamp(m_y + 2, 0, 447);
                default: m_y = clamp(m_y - 2, 0, 447);
            endcase
        end
        checks++;
        if (topLeftX !== 11'(m_x) || topLeftY !== 11'(m_y) || moveDone !== 1'b1) begin
            errors++;
            $display("FAIL move_pos: got x=%0d y=%0d done=%0b expected x=%0d y=%0d done=1",
                     topLeftX, topLeftY, moveDone, m_x, m_y);
        end
        tick();
        checks++;
        if (moveDone !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: got %0b expected 0", moveDone);
        end
    endtask

    task automatic test_reset();
        resetN = 1'b1; startOfFrame = 1'b0; collisionValid = 1'b0; collisionReq = 2'd0;
        tick();
        apply_reset();
        repeat (3) tick();
        checks++;
        if (topLeftX !== 11'd280 || topLeftY !== 11'd185 || moveDone !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got x=%0d y=%0d done=%0b expected x=280 y=185 done=0",
                     topLeftX, topLeftY, moveDone);
        end
    endtask

    task automatic test_first_move();
        apply_reset();
        run_frame(4'b0000, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic test_forced_right();
        apply_reset();
        run_frame(4'b1110, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        checks++;
        if (random_move !== 2'b00 || topLeftX !== 11'd282) begin
            errors++;
            $display("FAIL forced_right: got dir=%0d x=%0d expected dir=0 x=282", random_move, topLeftX);
        end
    endtask

    task automatic test_all_blocked();
        logic [10:0] px, py;
        px = topLeftX; py = topLeftY;
        run_frame(4'b1111, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        checks++;
        if (stuck !== 1'b1 || topLeftX !== px || topLeftY !== py) begin
            errors++;
            $display("FAIL all_blocked: got stuck=%0b x=%0d y=%0d expected stuck=1 x=%0d y=%0d",
                     stuck, topLeftX, topLeftY, px, py);
        end
    endtask

    task automatic test_hold();
        logic [1:0] first_dir, cur;
        apply_reset();
        run_frame(4'b0000, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        first_dir = random_move;
        for (int f = 2; f <= 8; f++) begin
            run_frame(4'b0000, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
            checks++;
            if (random_move !== first_dir) begin
                errors++;
                $display("FAIL hold_frame%0d: got %0d expected %0d", f, random_move, first_dir);
            end
        end
        run_frame(4'b0000, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        run_frame(4'b0000, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        cur = random_move;
        run_frame(4'b0001 << cur, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        checks++;
        if (random_move === cur) begin
            errors++;
            $display("FAIL early_repick: got %0d required a direction other than %0d", random_move, cur);
        end
    endtask

    task automatic test_saturate_right();
        apply_reset();
        repeat (163) run_frame(4'b1110, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        checks++;
        if (topLeftX !== 11'd606) begin
            errors++;
            $display("FAIL approach_edge: got x=%0d expected 606", topLeftX);
        end
        run_frame(4'b1110, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        checks++;
        if (topLeftX !== 11'd607) begin
            errors++;
            $display("FAIL sat_xmax: got x=%0d expected 607", topLeftX);
        end
        run_frame(4'b0001, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        checks++;
        if (random_move === 2'b00 || topLeftX > 11'd607) begin
            errors++;
            $display("FAIL edge_repick: got dir=%0d x=%0d expected dir!=0 x<=607", random_move, topLeftX);
        end
    endtask

    task automatic test_timing_edges();
        // coincident hit completes the all-blocked set
        run_frame(4'b1110, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
        checks++;
        if (stuck !== 1'b1) begin
            errors++;
            $display("FAIL sof_hit: got stuck=%0b expected 1", stuck);
        end
        // DECIDE-cycle hit on RIGHT carries into the next frame
        run_frame(4'b0000, 1'b0, 2'd0, 1'b1, 2'd0, 1'b1);
        run_frame(4'b1110, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        checks++;
        if (stuck !== 1'b1) begin
            errors++;
            $display("FAIL decide_hit_carry: got stuck=%0b expected 1", stuck);
        end
        run_frame(4'b0000, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        // reset pulsed during MOVE aborts the frame
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        tick();
        apply_reset();
        repeat (2) tick();
        checks++;
        if (topLeftX !== 11'd280 || topLeftY !== 11'd185 || moveDone !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_move: got x=%0d y=%0d done=%0b expected x=280 y=185 done=0",
                     topLeftX, topLeftY, moveDone);
        end
        run_frame(4'b0000, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic test_random_frames();
        for (int n = 0; n < 60; n++) begin
            run_frame(4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)),
                      1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_first_move();
        test_forced_right();
        test_all_blocked();
        test_hold();
        test_saturate_right();
        test_timing_edges();
        test_random_frames();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
